// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the inst/data sram-like request arbiter.
package sram_req_arbiter_pkg;

  // Which requester an accepted transaction belongs to.
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // sram-like transfer size codes.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Instruction fetches never carry strobes; the bridge still expects all lanes enabled.
  localparam logic [3:0] INST_WSTRB = 4'b1111;

  // One requester's command fields as presented to the master port.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sram_cmd_t;

endpackage

// File: rtl/sram_order_fifo.sv
// 1-bit order FIFO: remembers which requester owns each accepted-but-unanswered
// transaction so in-order responses can be steered back to the right side.
module sram_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             do_push, do_pop;

  // Next-state for pointers, occupancy and storage; full blocks a push even alongside a pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    head     = mem_q[rd_ptr_q];

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage for owner bits.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only read once count says it was written.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like master port between the inst and data requesters.
// Data wins by default; a starvation counter forces an inst grant, a lock keeps
// a stalled request stable, and an order FIFO routes in-order responses.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        err_unexp
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  owner_e      grant, lock_owner_q, lock_owner_d;
  logic        lock_q, lock_d, lock_live, grant_req, accept, resp;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic        err_unexp_q, err_unexp_d;
  sram_cmd_t   inst_cmd, data_cmd, grant_cmd;
  logic        fifo_head, fifo_full, fifo_empty;

  // Grant selection, master-port mux and zero-latency handshake routing.
  always_comb begin
    inst_cmd  = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata,
                  wstrb: INST_WSTRB};
    data_cmd  = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata,
                  wstrb: data_wstrb};
    // A lock only holds while its owner is still asking.
    lock_live = lock_q && ((lock_owner_q == OWNER_INST) ? inst_req : data_req);

    if (lock_live)                              grant = lock_owner_q;
    else if (starve_q == STARVE_MAX && inst_req) grant = OWNER_INST;
    else if (data_req)                          grant = OWNER_DATA;
    else if (inst_req)                          grant = OWNER_INST;
    else                                        grant = OWNER_DATA;

    grant_req = (grant == OWNER_INST) ? inst_req : data_req;
    grant_cmd = (grant == OWNER_INST) ? inst_cmd : data_cmd;

    m_req   = grant_req && !fifo_full;
    m_wr    = grant_cmd.wr;
    m_size  = grant_cmd.size;
    m_addr  = grant_cmd.addr;
    m_wdata = grant_cmd.wdata;
    m_wstrb = grant_cmd.wstrb;

    accept       = m_req && m_addr_ok;
    inst_addr_ok = accept && (grant == OWNER_INST);
    data_addr_ok = accept && (grant == OWNER_DATA);

    resp         = m_data_ok && !fifo_empty;
    inst_data_ok = resp && (fifo_head == OWNER_INST);
    data_data_ok = resp && (fifo_head == OWNER_DATA);
    inst_rdata   = inst_data_ok ? m_rdata : inst_rdata_q;
    data_rdata   = data_data_ok ? m_rdata : data_rdata_q;
  end

  // Next-state for lock, starvation counter, held read data and the error flag.
  always_comb begin
    lock_d       = m_req && !m_addr_ok;
    lock_owner_d = grant;
    inst_rdata_d = inst_rdata;
    data_rdata_d = data_rdata;
    err_unexp_d  = err_unexp_q || (m_data_ok && fifo_empty);

    if ((accept && grant == OWNER_INST) || !inst_req) begin
      starve_d = '0;
    end else if (accept && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Arbitration and response state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
      starve_q     <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      err_unexp_q  <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      err_unexp_q  <= err_unexp_d;
    end
  end

  assign err_unexp = err_unexp_q;

  sram_order_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (resp),
    .din   (grant),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_sram_req_arbiter;

  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr, m_addr_ok, m_data_ok;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, m_rdata;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr, err_unexp;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: owner queue (0 = inst, 1 = data) in acceptance order.
  bit          mdl_q[$];
  int          mdl_starve;
  bit          mdl_lock, mdl_lock_owner, mdl_err, mdl_inst_acc, mdl_data_acc;
  logic [31:0] mdl_inst_rdata, mdl_data_rdata;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .OUTSTANDING  (OUTSTANDING),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_rdata      (m_rdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .err_unexp    (err_unexp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: derive every output from the rules, compare, then step the model.
  always @(negedge clk) begin : model_cmp
    bit          g, greq, e_mreq, e_acc, pop, head_data, e_iok, e_dok;
    logic [31:0] e_ird, e_drd, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    bit          e_wr;
    #2;
    if (reset) begin
      mdl_q.delete();
      mdl_starve = 0; mdl_lock = 0; mdl_lock_owner = 0; mdl_err = 0;
      mdl_inst_acc = 0; mdl_data_acc = 0;
      mdl_inst_rdata = '0; mdl_data_rdata = '0;
    end else begin
      if (mdl_lock && (mdl_lock_owner ? data_req : inst_req)) g = mdl_lock_owner;
      else if (mdl_starve == STARVE_LIMIT && inst_req)        g = 1'b0;
      else if (data_req)                                      g = 1'b1;
      else                                                    g = 1'b0;
      greq      = g ? data_req : inst_req;
      e_mreq    = greq && (mdl_q.size() < OUTSTANDING);
      e_acc     = e_mreq && m_addr_ok;
      pop       = m_data_ok && (mdl_q.size() != 0);
      head_data = pop ? mdl_q[0] : 1'b0;
      e_iok     = pop && !head_data;
      e_dok     = pop && head_data;
      e_ird     = e_iok ? m_rdata : mdl_inst_rdata;
      e_drd     = e_dok ? m_rdata : mdl_data_rdata;
      e_wr      = g ? data_wr    : inst_wr;
      e_size    = g ? data_size  : inst_size;
      e_addr    = g ? data_addr  : inst_addr;
      e_wdata   = g ? data_wdata : inst_wdata;
      e_wstrb   = g ? data_wstrb : 4'hF;

      check("mdl_m_req",        m_req,        e_mreq);
      check("mdl_inst_addr_ok", inst_addr_ok, e_acc && !g);
      check("mdl_data_addr_ok", data_addr_ok, e_acc && g);
      check("mdl_inst_data_ok", inst_data_ok, e_iok);
      check("mdl_data_data_ok", data_data_ok, e_dok);
      check("mdl_inst_rdata",   inst_rdata,   e_ird);
      check("mdl_data_rdata",   data_rdata,   e_drd);
      check("mdl_err_unexp",    err_unexp,    mdl_err);
      if (e_mreq) begin
        check("mdl_m_wr",    m_wr,    e_wr);
        check("mdl_m_size",  m_size,  e_size);
        check("mdl_m_addr",  m_addr,  e_addr);
        check("mdl_m_wdata", m_wdata, e_wdata);
        check("mdl_m_wstrb", m_wstrb, e_wstrb);
      end

      if (m_data_ok && mdl_q.size() == 0) mdl_err = 1'b1;
      if (pop) void'(mdl_q.pop_front());
      if (e_acc) mdl_q.push_back(g);
      mdl_inst_rdata = e_ird;
      mdl_data_rdata = e_drd;
      mdl_lock       = e_mreq && !m_addr_ok;
      mdl_lock_owner = g;
      mdl_inst_acc   = e_acc && !g;
      mdl_data_acc   = e_acc && g;
      if (e_acc && !g)  mdl_starve = 0;
      else if (!inst_req) mdl_starve = 0;
      else if (e_acc && mdl_starve < STARVE_LIMIT) mdl_starve++;
    end
  end

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    data_wstrb = '0; m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #3;
    check("rst_m_req",        m_req,        1'b0);
    check("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    check("rst_data_addr_ok", data_addr_ok, 1'b0);
    check("rst_inst_data_ok", inst_data_ok, 1'b0);
    check("rst_data_data_ok", data_data_ok, 1'b0);
    check("rst_inst_rdata",   inst_rdata,   32'h0);
    check("rst_data_rdata",   data_rdata,   32'h0);
    check("rst_err_unexp",    err_unexp,    1'b0);
    check("rst_m_wstrb",      m_wstrb,      4'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #3;
  endtask

  // Answer everything outstanding, within a fixed cycle budget.
  task automatic drain();
    for (int i = 0; i < 20 && mdl_q.size() > 0; i++) begin
      @(negedge clk);
      idle_inputs();
      m_data_ok = 1'b1;
      m_rdata   = $urandom;
      #3;
    end
    check("drain_outstanding", mdl_q.size(), 0);
    @(negedge clk);
    idle_inputs();
    #3;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Lone inst read with a response three cycles after acceptance.
    @(negedge clk); inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1; #3;
    check("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    check("t1_m_addr",       m_addr,       32'hBFC0_0000);
    check("t1_m_wstrb",      m_wstrb,      4'hF);
    @(negedge clk); idle_inputs(); #3;
    @(negedge clk); idle_inputs(); #3;
    @(negedge clk); m_data_ok = 1; m_rdata = 32'h3C1D_8000; #3;
    check("t1_inst_data_ok", inst_data_ok, 1'b1);
    check("t1_inst_rdata",   inst_rdata,   32'h3C1D_8000);
    check("t1_data_data_ok", data_data_ok, 1'b0);
    @(negedge clk); idle_inputs(); #3;
    check("t1_inst_rdata_hold", inst_rdata, 32'h3C1D_8000);

    // Both held: eight data grants, then a forced inst grant, then data again.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h1000_0000 + 32'(i);
      data_req = 1; data_addr = 32'h2000_0000 + 32'(i); data_wstrb = 4'h3;
      m_addr_ok = 1; m_data_ok = (mdl_q.size() > 0); m_rdata = 32'(i);
      #3;
      if (i == 8) check("t2_forced_inst", inst_addr_ok, 1'b1);
      else        check("t2_data_grant",  data_addr_ok, 1'b1);
    end
    drain();

    // Order: data, inst, data accepted; responses routed in that order.
    @(negedge clk); data_req = 1; data_addr = 32'hA0; m_addr_ok = 1; #3;
    @(negedge clk); idle_inputs(); inst_req = 1; inst_addr = 32'hB0; m_addr_ok = 1; #3;
    @(negedge clk); idle_inputs(); data_req = 1; data_addr = 32'hC0; m_addr_ok = 1; #3;
    @(negedge clk); idle_inputs(); m_data_ok = 1; m_rdata = 32'h11; #3;
    check("t3_r1_data_ok", data_data_ok, 1'b1);
    check("t3_r1_rdata",   data_rdata,   32'h11);
    check("t3_r1_inst_ok", inst_data_ok, 1'b0);
    @(negedge clk); m_data_ok = 1; m_rdata = 32'h22; #3;
    check("t3_r2_inst_ok", inst_data_ok, 1'b1);
    check("t3_r2_rdata",   inst_rdata,   32'h22);
    check("t3_r2_hold",    data_rdata,   32'h11);
    @(negedge clk); m_data_ok = 1; m_rdata = 32'h33; #3;
    check("t3_r3_data_ok", data_data_ok, 1'b1);
    check("t3_r3_rdata",   data_rdata,   32'h33);
    @(negedge clk); idle_inputs(); #3;

    // Full: four accepts block the fifth until a response frees a slot.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_req = 1; data_addr = 32'h300 + 32'(4 * i); m_addr_ok = 1; #3;
      check("t4_fill", data_addr_ok, 1'b1);
    end
    @(negedge clk); m_data_ok = 1; m_rdata = 32'h44; #3;
    check("t4_full_m_req", m_req,        1'b0);
    check("t4_pop",        data_data_ok, 1'b1);
    @(negedge clk); m_data_ok = 0; #3;
    check("t4_freed_m_req", m_req, 1'b1);
    drain();

    // Stall on data; a later inst request must wait for the data accept.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_req = 1; data_addr = 32'hD000_0040; m_addr_ok = 0;
      inst_req = (i >= 2); inst_addr = 32'h0000_0400;
      #3;
      check("t5_m_req",        m_req,        1'b1);
      check("t5_m_addr",       m_addr,       32'hD000_0040);
      check("t5_no_inst_ok",   inst_addr_ok, 1'b0);
    end
    @(negedge clk); m_addr_ok = 1; #3;
    check("t5_data_accept", data_addr_ok, 1'b1);
    @(negedge clk); data_req = 0; #3;
    check("t5_inst_accept", inst_addr_ok, 1'b1);

    // Stall on inst; a rising data request must not steal the locked port.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      inst_req = 1; inst_addr = 32'h0000_0800;
      data_req = (i >= 1); data_addr = 32'hD000_0080;
      #3;
      check("t5b_m_addr",     m_addr,       32'h0000_0800);
      check("t5b_no_data_ok", data_addr_ok, 1'b0);
    end
    @(negedge clk); m_addr_ok = 1; #3;
    check("t5b_inst_accept", inst_addr_ok, 1'b1);
    drain();

    // Reset with two outstanding: stale responses are flagged, not routed.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); data_req = 1; data_addr = 32'h500 + 32'(i); m_addr_ok = 1; #3;
    end
    do_reset();
    @(negedge clk); m_data_ok = 1; m_rdata = 32'hDEAD_BEEF; #3;
    check("t6_no_inst_ok", inst_data_ok, 1'b0);
    check("t6_no_data_ok", data_data_ok, 1'b0);
    @(negedge clk); idle_inputs(); #3;
    check("t6_err_unexp", err_unexp, 1'b1);
    @(negedge clk); #3;
    check("t6_err_sticky", err_unexp, 1'b1);
    do_reset();

    // Randomized traffic: requesters hold pending requests, bridge stalls and answers at random.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!(inst_req && !mdl_inst_acc && $urandom_range(9) != 0)) begin
        inst_req   = ($urandom_range(2) == 0);
        inst_wr    = ($urandom_range(15) == 0);
        inst_size  = 2'($urandom_range(2));
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if (!(data_req && !mdl_data_acc && $urandom_range(9) != 0)) begin
        data_req   = ($urandom_range(3) != 0);
        data_wr    = 1'($urandom_range(1));
        data_size  = 2'($urandom_range(2));
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_wstrb = 4'($urandom_range(15));
      end
      m_addr_ok = ($urandom_range(3) != 0);
      m_data_ok = (mdl_q.size() > 0) && ($urandom_range(1) == 1);
      m_rdata   = $urandom;
      #3;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
